fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 Parameter DEPTH, default 4; instruction buffer entries and max in-flight credit; legal values 2, 4, 8.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  response valid; responses return in request order, latency >= 1 cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken from EX; flush fetch stream.
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 if_id_valid  output  1  instruction available to decode.
REQ-013 if_id_ready  input  1  decode accepts; low = decode stall.
REQ-014 if_id_instr  output  32  instruction word.
REQ-015 if_id_pc  output  32  address of if_id_instr.

Function
REQ-016 FSM states BOOT, FETCH; reset enters BOOT; BOOT -> FETCH unconditionally after one cycle; FETCH has no exit except reset.
REQ-017 imem_req_valid = (state == FETCH) && (outstanding + count < DEPTH); outstanding counts accepted requests with no response yet, including to-be-discarded ones.
REQ-018 imem_addr = pc register; on request handshake (valid && ready) pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-019 imem_req_valid, once asserted, holds with stable imem_addr until accepted or a redirect occurs.
REQ-020 Response not marked discard: {pc_of_request, imem_rdata} pushed to buffer; visible on if_id_* the following cycle.
REQ-021 Buffer is FIFO; if_id_valid = count != 0; pop on if_id_valid && if_id_ready; if_id_* hold stable while valid && !ready.
REQ-022 Simultaneous push and pop allowed; count unchanged; full throughput one instruction/cycle with 1-cycle memory.
REQ-023 Overflow impossible by REQ-017 credit; a push into a full buffer is a design error flagged by assertion.
REQ-024 Redirect (any state after BOOT): buffer cleared next cycle, pc <= {redirect_pc[31:2], 2'b00}, discard <= outstanding after this cycle's request/response updates.
REQ-025 Request accepted in the redirect cycle is old-stream: it is counted into discard.
REQ-026 Response arriving in the redirect cycle is dropped, not pushed.
REQ-027 Pop in the redirect cycle completes normally for decode; buffer is still cleared.
REQ-028 While discard != 0, each response decrements discard and is dropped; new-stream requests may issue concurrently subject to REQ-017.
REQ-029 Redirect during BOOT: pc takes redirect target; FSM still goes to FETCH.
REQ-030 Back-to-back redirects: last one wins; discard recomputed each time.
REQ-031 Latency with 1-cycle memory and ready decode: request cycle N, response N+1, if_id_valid N+2.

Reset
REQ-032 On rst low, immediately: state=BOOT, pc=RESET_PC, outstanding=0, discard=0, buffer count=0.
REQ-033 During reset outputs: imem_req_valid=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=32'h0000_0013 (NOP), if_id_pc=0.
REQ-034 Reset mid-operation abandons in-flight requests; memory is also reset by the same rst.

Structure
REQ-035 Shared package fetch_pkg holds XLEN=32, NOP_INSTR=32'h0000_0013, fetch state enum, buffer entry struct {pc, instr}.
REQ-036 One sub-module fetch_fifo: synchronous FIFO, parameter DEPTH, push/pop/flush, count output; rst async active-low.

Verification
REQ-037 Reset release, 1-cycle memory, decode ready: addresses 0x0,0x4,0x8... one per cycle; first if_id_valid 2 cycles after first request with if_id_pc=0.
REQ-038 Decode stalls 6 cycles: exactly DEPTH instructions buffered, imem_req_valid drops, if_id_* stable; on release pc sequence continues with no gap or duplicate.
REQ-039 Redirect to 0x100 with 2 requests outstanding on 3-cycle memory: both old responses dropped, next if_id_pc=0x100, then 0x104.
REQ-040 Redirect to 0x203: fetch from 0x200; redirect same cycle as response and pop: response dropped, pop completes, buffer empty next cycle.
REQ-041 RESET_PC=32'hFFFF_FFF8: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-042 rst asserted mid-stream with buffer full: if_id_valid=0 immediately, restart from RESET_PC after BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    StBoot,
    StFetch
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries for decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when a pop frees a slot the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // The fetch credit scheme must never let a response land in a full buffer.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop))
    else $error("fetch_fifo: push into full buffer");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request stream, in-order response
// capture into a small buffer, and redirect handling with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  input  logic        if_id_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_data;
  logic          req_hs;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid  = (state_q == StFetch) && (credit_used < (CW + 1)'(DEPTH));
  assign imem_addr       = pc_q;
  assign req_hs          = imem_req_valid && imem_req_ready;

  // Responses still owed to a flushed stream, or arriving in a redirect cycle, are dropped.
  assign push            = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  // New-stream fetches are sequential, so the response pc is tracked by a
  // running counter instead of a per-request pc queue.
  assign push_data.pc    = rsp_pc_q;
  assign push_data.instr = imem_rdata;

  assign if_id_valid = !fifo_empty;
  assign pop         = if_id_valid && if_id_ready;
  assign if_id_instr = if_id_valid ? fifo_head.instr : NOP_INSTR;
  assign if_id_pc    = if_id_valid ? fifo_head.pc : 32'h0000_0000;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StBoot;
    else      state_q <= state_d;
  end

  // FSM next state: one boot cycle, then fetch until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StBoot;
    endcase
  end

  // Next-state for fetch pointers and in-flight bookkeeping.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d      = redirect_target;
      rsp_pc_d  = redirect_target;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d = outstanding_d;
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (push)   rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  // Fetch pointer and in-flight counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
